// File: rtl/layer_stream_tx_x_pkg.sv
// Shared defaults and state encoding for layer-input stream transmitters.
package layer_stream_tx_x_pkg;
  localparam int LST_WIDTH = 16;
  localparam int LST_LEN   = 24;
  localparam int LST_ADDR  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } tx_state_t;
endpackage

// File: rtl/layer_stream_tx_x_memory1.sv
// Single-port vector store: synchronous write, registered read that holds its
// value until the next read is issued.
module memory1
  import layer_stream_tx_x_pkg::*;
#(
  parameter int WIDTH = LST_WIDTH,
  parameter int LEN   = LST_LEN,
  parameter int ADDR  = LST_ADDR
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [ADDR-1:0]  addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [LEN];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/layer_stream_tx_x.sv
// Streams a stored LEN-word vector over a valid/ready handshake, one word per
// cycle when the receiver keeps up, holding data stable under back-pressure.
module layer_stream_tx_x
  import layer_stream_tx_x_pkg::*;
#(
  parameter int WIDTH = LST_WIDTH,
  parameter int LEN   = LST_LEN,
  parameter int ADDR  = LST_ADDR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR-1:0]         wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] m_data_out_x,
  output logic                    m_valid_x,
  input  logic                    m_ready_x
);

  localparam int CW = ADDR + 1;
  localparam logic [CW-1:0] LEN_C = CW'(LEN);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  tx_state_t state_q, state_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] hs_cnt_q, hs_cnt_d;
  logic dv_q, dv_d;
  logic skid_vld_q, skid_vld_d;
  logic signed [WIDTH-1:0] skid_q, skid_d;
  logic done_q, done_d;

  logic mem_we, mem_re, issue, hs;
  logic [ADDR-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;

  // The memory read register is the front entry; skid_q is the second entry.
  memory1 #(.WIDTH(WIDTH), .LEN(LEN), .ADDR(ADDR)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (wr_data),
    .rdata (mem_rdata)
  );

  assign mem_addr     = mem_we ? wr_addr : rd_ptr_q[ADDR-1:0];
  assign m_valid_x    = dv_q || skid_vld_q;
  assign hs           = m_valid_x && m_ready_x;
  assign m_data_out_x = skid_vld_q ? skid_q : (dv_q ? $signed(mem_rdata) : '0);
  assign busy         = (state_q == STREAM);
  assign done         = done_q;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    hs_cnt_d   = hs_cnt_q;
    dv_d       = dv_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    issue      = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_en && ({1'b0, wr_addr} < LEN_C)) mem_we = 1'b1;
        if (start) begin
          state_d    = STREAM;
          rd_ptr_d   = '0;
          hs_cnt_d   = '0;
          dv_d       = 1'b0;
          skid_vld_d = 1'b0;
        end
      end

      STREAM: begin
        // A new read overwrites the front entry, so it is only issued while the
        // skid slot is free to catch a front word the receiver does not take.
        issue = (rd_ptr_q < LEN_C) && !skid_vld_q;
        if (issue) begin
          mem_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + ONE_C;
        end

        if (skid_vld_q) begin
          if (hs) skid_vld_d = 1'b0;
        end else begin
          if (dv_q && !hs && issue) begin
            skid_d     = $signed(mem_rdata);
            skid_vld_d = 1'b1;
          end
          if (issue)   dv_d = 1'b1;
          else if (hs) dv_d = 1'b0;
        end

        if (hs) begin
          hs_cnt_d = hs_cnt_q + ONE_C;
          if (hs_cnt_q == LEN_C - ONE_C) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      hs_cnt_q   <= '0;
      dv_q       <= 1'b0;
      skid_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      hs_cnt_q   <= hs_cnt_d;
      dv_q       <= dv_d;
      skid_vld_q <= skid_vld_d;
      done_q     <= done_d;
    end
  end

  // Skid data is qualified by skid_vld_q and needs no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_layer_stream_tx_x.sv
// Directed bench for layer_stream_tx_x with a queue scoreboard of expected words.
module tb_layer_stream_tx_x;

  logic clk;
  logic reset;
  logic wr_en;
  logic [4:0] wr_addr;
  logic [15:0] wr_data;
  logic start;
  logic busy;
  logic done;
  logic signed [15:0] m_data_out_x;
  logic m_valid_x;
  logic m_ready_x;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int run_hs = 0;
  int run_first = -1;
  int run_last = -1;
  int done_total = 0;
  bit prev_vld = 0;
  bit prev_rdy = 0;

  logic signed [15:0] model [24];
  logic signed [15:0] sb [$];

  layer_stream_tx_x dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .m_data_out_x (m_data_out_x),
    .m_valid_x    (m_valid_x),
    .m_ready_x    (m_ready_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compares every presented word against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_vld && !prev_rdy) check("valid_hold", m_valid_x, 1'b1);
      if (m_valid_x) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          check("present", m_data_out_x, sb[0]);
          if (m_ready_x) begin
            void'(sb.pop_front());
            if (run_first < 0) run_first = cyc + 1;
            run_last = cyc + 1;
            run_hs++;
          end
        end
      end
      if (done) begin
        done_total++;
        check("busy_at_done", busy, 1'b0);
        check("valid_at_done", m_valid_x, 1'b0);
      end
      prev_vld = m_valid_x;
      prev_rdy = m_ready_x;
    end
  end

  task automatic write_word(input logic [4:0] a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (a < 24) model[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  // mode 0: ready=1, 1: 5-cycle stall on word special_at, 2: random ready,
  // 3: ready toggling, 4: write+start injected mid-stream, 5: reset at word special_at
  task automatic stream(input int mode, input int special_at, input bit with_wr,
                        input logic [4:0] waddr, input logic [15:0] wdata,
                        output int e0, output int occ);
    int lowcnt = 0;
    int k = 0;
    bit inj = 0;
    bit aborted = 0;
    if (with_wr) begin
      wr_en = 1'b1;
      wr_addr = waddr;
      wr_data = wdata;
      if (waddr < 24) model[waddr] = wdata;
    end
    for (int i = 0; i < 24; i++) sb.push_back(model[i]);
    run_hs = 0;
    run_first = -1;
    run_last = -1;
    start = 1'b1;
    e0 = cyc + 1;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    while (!done && !aborted && k < 500) begin
      wr_en = 1'b0;
      start = 1'b0;
      m_ready_x = 1'b1;
      case (mode)
        1: if (run_hs == special_at && m_valid_x && lowcnt < 5) begin
             m_ready_x = 1'b0;
             lowcnt++;
           end
        2: m_ready_x = 1'($urandom_range(0, 1));
        3: m_ready_x = (k % 2 == 0);
        4: if (run_hs == special_at && !inj) begin
             wr_en = 1'b1;
             wr_addr = 5'd3;
             wr_data = 16'h7FFF;
             start = 1'b1;
             inj = 1'b1;
           end
        5: if (run_hs == special_at) begin
             reset = 1'b1;
             #1;
             check("rst_valid", m_valid_x, 1'b0);
             check("rst_data", m_data_out_x, 16'sd0);
             check("rst_busy", busy, 1'b0);
             check("rst_done", done, 1'b0);
             #1;
             reset = 1'b0;
             sb.delete();
             aborted = 1'b1;
           end
        default: ;
      endcase
      if (!aborted) step();
      k++;
    end
    wr_en = 1'b0;
    start = 1'b0;
    m_ready_x = 1'b1;
    occ = cyc - e0;
    if (aborted) step();
    else check("done_seen", done, 1'b1);
  endtask

  initial begin
    int e0;
    int occ;
    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    m_ready_x = 1'b1;
    step();
    step();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_valid", m_valid_x, 1'b0);
    check("reset_data", m_data_out_x, 16'sd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 24; i++) write_word(5'(i), 16'(i * 3 - 30));

    // Full-rate stream
    stream(0, 0, 1'b0, 5'd0, 16'd0, e0, occ);
    check("t1_occupancy", occ, 25);
    check("t1_first_hs_edge", run_first, e0 + 2);
    check("t1_last_hs_edge", run_last, e0 + 25);
    check("t1_hs_count", run_hs, 24);
    check("t1_sb_empty", sb.size(), 0);
    step();
    check("t1_done_pulse", done, 1'b0);
    check("t1_busy_after", busy, 1'b0);

    // Five-cycle stall while word 7 is presented
    stream(1, 7, 1'b0, 5'd0, 16'd0, e0, occ);
    check("t2_occupancy", occ, 30);
    check("t2_hs_count", run_hs, 24);
    check("t2_sb_empty", sb.size(), 0);

    // Three back-to-back runs with random ready
    for (int r = 0; r < 3; r++) begin
      stream(2, 0, 1'b0, 5'd0, 16'd0, e0, occ);
      check("t3_hs_count", run_hs, 24);
      check("t3_sb_empty", sb.size(), 0);
    end

    // Write and start during STREAM must be ignored
    stream(4, 5, 1'b0, 5'd0, 16'd0, e0, occ);
    check("t4_occupancy", occ, 25);
    check("t4_hs_count", run_hs, 24);
    step();
    check("t4_no_restart", busy, 1'b0);
    stream(0, 0, 1'b0, 5'd0, 16'd0, e0, occ);
    check("t4_replay_hs", run_hs, 24);

    // Reset at word 10, then replay from word 0
    stream(5, 10, 1'b0, 5'd0, 16'd0, e0, occ);
    check("t5_after_rst_busy", busy, 1'b0);
    stream(0, 0, 1'b0, 5'd0, 16'd0, e0, occ);
    check("t5_replay_first", run_first, e0 + 2);
    check("t5_replay_hs", run_hs, 24);

    // Extremes, out-of-range write, write+start in the same cycle, toggling ready
    write_word(5'd1, 16'h7FFF);
    write_word(5'd31, 16'h1234);
    stream(3, 0, 1'b1, 5'd0, 16'h8000, e0, occ);
    check("t6_hs_count", run_hs, 24);
    check("t6_sb_empty", sb.size(), 0);
    step();

    check("done_total", done_total, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
